// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and helpers for the display pipeline (binary-to-BCD converter and
// the seven-segment driver downstream of it).
//   bcd_digit_t  : one BCD nibble
//   cnv_state_t  : converter FSM states
//   pow10(n)     : 10**n as a 64-bit constant, used to derive the largest
//                  displayable decimal value for a given digit count
// -----------------------------------------------------------------------------
package display_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        CNV_IDLE,
        CNV_SHIFT,
        CNV_DONE
    } cnv_state_t;

    // 64 bits comfortably holds 10**8, the largest power needed (8 digits).
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// -----------------------------------------------------------------------------
// bcd_dabble_step
// Combinational add-3 stage of the double-dabble algorithm: every BCD nibble
// that is 5 or more gets 3 added so that the following left shift carries
// correctly into the next decimal digit.
// Ports:
//   i_digits  in   [NUM_SEGMENTS-1:0][3:0]  BCD accumulator before adjust
//   o_digits  out  [NUM_SEGMENTS-1:0][3:0]  BCD accumulator after add-3
// -----------------------------------------------------------------------------
module bcd_dabble_step
    import display_pkg::*;
#(
    parameter int NUM_SEGMENTS = 4
) (
    input  logic [NUM_SEGMENTS-1:0][3:0] i_digits,
    output logic [NUM_SEGMENTS-1:0][3:0] o_digits
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SEGMENTS; gi++) begin : g_nibble
            bcd_digit_t w_nib;
            assign w_nib        = i_digits[gi];
            // Nibbles above 9 only occur for overflowing inputs; they wrap
            // harmlessly because the final result is forced to all 9s then.
            assign o_digits[gi] = (w_nib >= 4'd5) ? bcd_digit_t'(w_nib + 4'd3) : w_nib;
        end
    endgenerate

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Iterative shift-add-3 (double-dabble) binary-to-BCD converter feeding the
// seven-segment driver. One conversion at a time with a start/ready handshake;
// the result outputs hold the last conversion so the display stays stable.
// Values that do not fit in NUM_SEGMENTS decimal digits display as all 9s with
// every digit point lit.
// Ports:
//   clk          in   1                         rising-edge clock
//   CPU_RESETN   in   1                         async active-low reset
//   start        in   1                         conversion request (taken when ready)
//   bin_in       in   BIN_WIDTH                 unsigned value, sampled on accept
//   ready        out  1                         idle, next start is accepted
//   done         out  1                         one-cycle pulse, outputs just updated
//   encoded      out  [NUM_SEGMENTS-1:0][3:0]   BCD digits, [0] = units
//   digit_point  out  [NUM_SEGMENTS-1:0]        all ones on overflow
//   overflow     out  1                         last value exceeded 10**N-1
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int BIN_WIDTH    = 16,
    parameter int NUM_SEGMENTS = 4
) (
    input  logic                          clk,
    input  logic                          CPU_RESETN,
    input  logic                          start,
    input  logic [BIN_WIDTH-1:0]          bin_in,
    output logic                          ready,
    output logic                          done,
    output logic [NUM_SEGMENTS-1:0][3:0]  encoded,
    output logic [NUM_SEGMENTS-1:0]       digit_point,
    output logic                          overflow
);

    localparam int                ACC_W     = 4 * NUM_SEGMENTS;
    localparam int                ITER_W    = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0]       MAX_DEC   = pow10(NUM_SEGMENTS) - 64'd1;
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_WIDTH - 1);

    // Reset is asserted asynchronously but released on a clock edge so that
    // the FSM never leaves reset with a metastable release.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    cnv_state_t                  r_state;
    cnv_state_t                  w_state_next;
    logic [BIN_WIDTH-1:0]        r_shreg;
    logic [ACC_W-1:0]            r_accum;
    logic [ITER_W-1:0]           r_iter;
    logic                        r_ovf;
    logic [ACC_W-1:0]            r_encoded;
    logic [NUM_SEGMENTS-1:0]     r_digit_point;
    logic                        r_overflow;
    logic                        r_done;

    logic [ACC_W-1:0]            w_accum_adj;
    logic [ACC_W+BIN_WIDTH-1:0]  w_shifted;
    logic                        w_accept;
    logic                        w_ovf_in;

    bcd_dabble_step #(
        .NUM_SEGMENTS (NUM_SEGMENTS)
    ) u_step (
        .i_digits (r_accum),
        .o_digits (w_accum_adj)
    );

    // Bits shifted out of the top of the accumulator are dropped; that only
    // happens for values already flagged as overflow.
    assign w_shifted = {w_accum_adj, r_shreg} << 1;
    assign w_accept  = start && (r_state == CNV_IDLE);
    // Compare in 64 bits so MAX_DEC is never truncated for narrow inputs.
    assign w_ovf_in  = (64'(bin_in) > MAX_DEC);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= CNV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CNV_IDLE:  if (start) w_state_next = CNV_SHIFT;
            CNV_SHIFT: if (r_iter == LAST_ITER) w_state_next = CNV_DONE;
            CNV_DONE:  w_state_next = CNV_IDLE;
            default:   w_state_next = CNV_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_shreg       <= '0;
            r_accum       <= '0;
            r_iter        <= '0;
            r_ovf         <= 1'b0;
            r_encoded     <= '0;
            r_digit_point <= '0;
            r_overflow    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CNV_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= bin_in;
                        r_accum <= '0;
                        r_iter  <= '0;
                        r_ovf   <= w_ovf_in;
                    end
                end
                CNV_SHIFT: begin
                    r_accum <= w_shifted[ACC_W+BIN_WIDTH-1:BIN_WIDTH];
                    r_shreg <= w_shifted[BIN_WIDTH-1:0];
                    r_iter  <= r_iter + 1'b1;
                end
                CNV_DONE: begin
                    r_encoded     <= r_ovf ? {NUM_SEGMENTS{4'd9}} : r_accum;
                    r_digit_point <= {NUM_SEGMENTS{r_ovf}};
                    r_overflow    <= r_ovf;
                    r_done        <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign ready       = (r_state == CNV_IDLE);
    assign done        = r_done;
    assign encoded     = r_encoded;
    assign digit_point = r_digit_point;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            CPU_RESETN;
    // 16-bit / 4-digit instance
    logic            start;
    logic [15:0]     bin_in;
    logic            ready;
    logic            done;
    logic [3:0][3:0] encoded;
    logic [3:0]      digit_point;
    logic            overflow;
    // 8-bit / 2-digit instance
    logic            start_s;
    logic [7:0]      bin_in_s;
    logic            ready_s;
    logic            done_s;
    logic [1:0][3:0] encoded_s;
    logic [1:0]      digit_point_s;
    logic            overflow_s;

    bin_to_bcd_seq #(.BIN_WIDTH(16), .NUM_SEGMENTS(4)) dut (
        .clk         (clk),
        .CPU_RESETN  (CPU_RESETN),
        .start       (start),
        .bin_in      (bin_in),
        .ready       (ready),
        .done        (done),
        .encoded     (encoded),
        .digit_point (digit_point),
        .overflow    (overflow)
    );

    bin_to_bcd_seq #(.BIN_WIDTH(8), .NUM_SEGMENTS(2)) dut_s (
        .clk         (clk),
        .CPU_RESETN  (CPU_RESETN),
        .start       (start_s),
        .bin_in      (bin_in_s),
        .ready       (ready_s),
        .done        (done_s),
        .encoded     (encoded_s),
        .digit_point (digit_point_s),
        .overflow    (overflow_s)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] enc;
        logic        ovf;
        logic [3:0]  dp;
        int          due;
        int          val;
    } exp_t;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t e_m;
    exp_t e_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (CPU_RESETN && done) begin
            if (q_m.size() == 0) begin
                chk("unexpected_done_m", 32'(encoded), 32'hFFFF_FFFF);
            end else begin
                e_m = q_m.pop_front();
                chk("enc_m", 32'(encoded), 32'(e_m.enc));
                chk("ovf_m", 32'(overflow), 32'(e_m.ovf));
                chk("dp_m", 32'(digit_point), 32'(e_m.dp));
                chk("lat_m", 32'(cyc), 32'(e_m.due));
                $display("main: bin_in=%0d encoded=%h overflow=%b dp=%b at cycle %0d",
                         e_m.val, encoded, overflow, digit_point, cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (CPU_RESETN && done_s) begin
            if (q_s.size() == 0) begin
                chk("unexpected_done_s", 32'(encoded_s), 32'hFFFF_FFFF);
            end else begin
                e_s = q_s.pop_front();
                chk("enc_s", 32'(encoded_s), 32'(e_s.enc[7:0]));
                chk("ovf_s", 32'(overflow_s), 32'(e_s.ovf));
                chk("dp_s", 32'(digit_point_s), 32'(e_s.dp[1:0]));
                chk("lat_s", 32'(cyc), 32'(e_s.due));
                $display("small: bin_in=%0d encoded=%h overflow=%b dp=%b at cycle %0d",
                         e_s.val, encoded_s, overflow_s, digit_point_s, cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready_m();
        int k;
        k = 0;
        @(negedge clk);
        while (!ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait_m", 32'(ready), 32'd1);
    endtask

    task automatic push_m(input int v, input logic [15:0] enc, input logic ovf, input int due);
        exp_t e;
        e.enc = enc;
        e.ovf = ovf;
        e.dp  = {4{ovf}};
        e.due = due;
        e.val = v;
        q_m.push_back(e);
    endtask

    // Start is accepted on the posedge after this negedge; done is then seen
    // at the negedge BIN_WIDTH+2 edges after the current count.
    task automatic issue_m(input logic [15:0] v, input logic [15:0] enc, input logic ovf,
                           input bit expect_done);
        wait_ready_m();
        start  = 1'b1;
        bin_in = v;
        if (expect_done) push_m(int'(v), enc, ovf, cyc + 18);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue_s(input logic [7:0] v, input logic [7:0] enc, input logic ovf);
        exp_t e;
        int k;
        k = 0;
        @(negedge clk);
        while (!ready_s && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait_s", 32'(ready_s), 32'd1);
        start_s  = 1'b1;
        bin_in_s = v;
        e.enc = {8'h00, enc};
        e.ovf = ovf;
        e.dp  = {2'b00, {2{ovf}}};
        e.due = cyc + 10;
        e.val = int'(v);
        q_s.push_back(e);
        @(negedge clk);
        start_s = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_enc"}, 32'(encoded), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_dp"}, 32'(digit_point), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        int k;
        CPU_RESETN = 1'b0;
        start      = 1'b0;
        bin_in     = 16'd0;
        start_s    = 1'b0;
        bin_in_s   = 8'd0;

        // Power-on reset: outputs idle every cycle while held.
        repeat (3) begin
            @(negedge clk);
            chk_reset_outputs("por");
        end
        CPU_RESETN = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("post_por");

        // Basic conversions, including the overflow boundary.
        issue_m(16'd1234,  16'h1234, 1'b0, 1'b1);
        issue_m(16'd0,     16'h0000, 1'b0, 1'b1);
        issue_m(16'd9999,  16'h9999, 1'b0, 1'b1);
        issue_m(16'd10000, 16'h9999, 1'b1, 1'b1);
        issue_m(16'd65535, 16'h9999, 1'b1, 1'b1);
        issue_m(16'd305,   16'h0305, 1'b0, 1'b1);

        // start held high: back-to-back conversions every 18 cycles; bin_in
        // changes during SHIFT must not affect the running conversion.
        wait_ready_m();
        start  = 1'b1;
        bin_in = 16'd111;
        c0     = cyc;
        push_m(111, 16'h0111, 1'b0, c0 + 18);
        @(negedge clk);
        bin_in = 16'd222;
        push_m(222, 16'h0222, 1'b0, c0 + 36);
        while (cyc < c0 + 19) @(negedge clk);
        start = 1'b0;

        // start while busy is ignored.
        issue_m(16'd500, 16'h0500, 1'b0, 1'b1);
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd42;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 16'd0;
        repeat (25) @(negedge clk);
        chk("hold_enc", 32'(encoded), 32'h0500);
        issue_m(16'd42, 16'h0042, 1'b0, 1'b1);
        repeat (25) @(negedge clk);
        chk("hold_enc2", 32'(encoded), 32'h0042);

        // Reset in the middle of SHIFT: outputs clear at once, no done.
        issue_m(16'd9000, 16'h9000, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        CPU_RESETN = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        repeat (2) begin
            @(negedge clk);
            chk_reset_outputs("mid_rst_hold");
        end
        CPU_RESETN = 1'b1;
        repeat (3) @(negedge clk);
        issue_m(16'd7, 16'h0007, 1'b0, 1'b1);

        // 8-bit / 2-digit instance.
        issue_s(8'd37,  8'h37, 1'b0);
        issue_s(8'd0,   8'h00, 1'b0);
        issue_s(8'd99,  8'h99, 1'b0);
        issue_s(8'd100, 8'h99, 1'b1);
        issue_s(8'd255, 8'h99, 1'b1);

        // Drain the scoreboards with a bounded wait.
        k = 0;
        while ((q_m.size() != 0 || q_s.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("pending_m", 32'(q_m.size()), 32'd0);
        chk("pending_s", 32'(q_s.size()), 32'd0);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
